// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and helpers for the reset sequencer.
//   seq_state_e  - sequencer states
//   clog2        - ceiling log2 usable in constant expressions
//   calc_cnt_w   - width of the shared hold/gap/timeout counter
package rst_seq_pkg;

   typedef enum logic [2:0] {
      StHold,
      StWaitAck,
      StGap,
      StDone,
      StFault
   } seq_state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned val);
      int unsigned res;
      res = 0;
      while ((longint'(1) << res) < longint'(val)) begin
         res++;
      end
      return res;
   endfunction

   // One counter serves all three counts, so it must hold the largest terminal value.
   function automatic int unsigned calc_cnt_w(input int unsigned hold_cycles,
                                              input int unsigned gap_cycles,
                                              input int unsigned ack_timeout);
      int unsigned max_val;
      max_val = hold_cycles;
      if (gap_cycles > max_val) max_val = gap_cycles;
      if (ack_timeout > max_val) max_val = ack_timeout;
      return clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// rst_seq_timer: up-counter shared by the hold, gap and ack-timeout counts.
// Ports:
//   clk_50m  - system clock
//   rst      - synchronous active-high reset, clears the count
//   clr      - clear the count this edge (state change / restart)
//   en       - advance the count this edge
//   term     - terminal value loaded by the caller for the current count
//   expired  - count has reached term; the count saturates there
module rst_seq_timer #(
   parameter int unsigned CNT_W = 11
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == term);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rst_seq.sv
// rst_seq: releases subsystem resets in order, each after the previous stage acks.
// A lost ack or an ack timeout forces all resets back on and raises a sticky fault;
// soft_rst_req restarts the whole sequence without a board reset.
// Ports:
//   clk_50m       - system clock
//   rst           - synchronous active-high reset
//   soft_rst_req  - single-cycle restart request
//   stage_ack     - per-stage ready levels (bit i valid once rst_out[i] is released)
//   rst_out       - per-stage active-high resets
//   seq_done      - all stages released and acknowledged
//   seq_fault     - sticky abort flag
//   fault_stage   - index of the stage that caused the last fault
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned N_STAGES    = 4,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 8,
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic                          clk_50m,
   input  logic                          rst,
   input  logic                          soft_rst_req,
   input  logic [N_STAGES-1:0]           stage_ack,
   output logic [N_STAGES-1:0]           rst_out,
   output logic                          seq_done,
   output logic                          seq_fault,
   output logic [clog2(N_STAGES)-1:0]    fault_stage
);

   localparam int unsigned CNT_W = calc_cnt_w(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
   localparam int unsigned IDX_W = clog2(N_STAGES);

   // Terminal values: a count of C cycles expires when the counter reads C-1.
   localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_TERM  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);

   seq_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
   // rst_out_q doubles as the (inverted) released-stage mask.
   logic [N_STAGES-1:0] rst_out_q, rst_out_d;
   logic                seq_done_q, seq_done_d;
   logic                seq_fault_q, seq_fault_d;
   logic [IDX_W-1:0]    fault_stage_q, fault_stage_d;

   logic [N_STAGES-1:0] acked, lost;
   logic [IDX_W-1:0]    lost_idx;

   logic                tmr_clr, tmr_en, tmr_exp;
   logic [CNT_W-1:0]    tmr_term;

   assign idx_nxt = idx_q + IDX_W'(1);

   // Acknowledged stages are the released ones, minus the one still being waited on.
   always_comb begin
      acked = ~rst_out_q;
      if (state_q == StWaitAck) begin
         acked[idx_q] = 1'b0;
      end
      lost = acked & ~stage_ack;
      lost_idx = '0;
      // Scan downwards so the lowest lost stage wins.
      for (int k = N_STAGES - 1; k >= 0; k--) begin
         if (lost[k]) lost_idx = IDX_W'(k);
      end
   end

   // Counter terminal value and enable follow the current state.
   always_comb begin
      tmr_term = '0;
      tmr_en   = 1'b0;
      case (state_q)
         StHold: begin
            tmr_term = HOLD_TERM;
            tmr_en   = 1'b1;
         end
         StWaitAck: begin
            tmr_term = TMO_TERM;
            tmr_en   = 1'b1;
         end
         StGap: begin
            tmr_term = GAP_TERM;
            tmr_en   = 1'b1;
         end
         default: begin
            tmr_term = '0;
            tmr_en   = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      rst_out_d     = rst_out_q;
      seq_done_d    = seq_done_q;
      seq_fault_d   = seq_fault_q;
      fault_stage_d = fault_stage_q;

      if (soft_rst_req) begin
         // fault_stage is deliberately kept for post-mortem.
         state_d     = StHold;
         idx_d       = '0;
         rst_out_d   = '1;
         seq_done_d  = 1'b0;
         seq_fault_d = 1'b0;
      end else if ((state_q == StWaitAck || state_q == StGap || state_q == StDone) && |lost) begin
         state_d       = StFault;
         idx_d         = '0;
         rst_out_d     = '1;
         seq_done_d    = 1'b0;
         seq_fault_d   = 1'b1;
         fault_stage_d = lost_idx;
      end else begin
         case (state_q)
            StHold: begin
               if (tmr_exp) begin
                  state_d      = StWaitAck;
                  idx_d        = '0;
                  rst_out_d[0] = 1'b0;
               end
            end
            StWaitAck: begin
               if (stage_ack[idx_q]) begin
                  if (idx_q == LAST_IDX) begin
                     state_d    = StDone;
                     seq_done_d = 1'b1;
                  end else begin
                     state_d = StGap;
                  end
               end else if (tmr_exp) begin
                  state_d       = StFault;
                  idx_d         = '0;
                  rst_out_d     = '1;
                  seq_fault_d   = 1'b1;
                  fault_stage_d = idx_q;
               end
            end
            StGap: begin
               if (tmr_exp) begin
                  state_d            = StWaitAck;
                  idx_d              = idx_nxt;
                  rst_out_d[idx_nxt] = 1'b0;
               end
            end
            default: begin
               // StDone and StFault hold until a loss, soft_rst_req or rst.
               state_d = state_q;
            end
         endcase
      end
   end

   // Restart the count on every state change and on any soft restart.
   assign tmr_clr = soft_rst_req || (state_d != state_q);

   rst_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_50m (clk_50m),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .term    (tmr_term),
      .expired (tmr_exp)
   );

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q       <= StHold;
         idx_q         <= '0;
         rst_out_q     <= '1;
         seq_done_q    <= 1'b0;
         seq_fault_q   <= 1'b0;
         fault_stage_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         rst_out_q     <= rst_out_d;
         seq_done_q    <= seq_done_d;
         seq_fault_q   <= seq_fault_d;
         fault_stage_q <= fault_stage_d;
      end
   end

   assign rst_out     = rst_out_q;
   assign seq_done    = seq_done_q;
   assign seq_fault   = seq_fault_q;
   assign fault_stage = fault_stage_q;

endmodule
